// File: rtl/config_tx_serializer_pkg.sv
// Shared types and derived timing helpers for the NanEye configuration serializer.
package config_tx_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SHIFT,
        DONE
    } state_e;

    // System clock cycles per serial bit (integer division, truncating).
    function automatic int unsigned bit_cycles(input int unsigned clock_period_ps,
                                               input int unsigned bit_period_ns);
        return (bit_period_ns * 1000) / clock_period_ps;
    endfunction

    function automatic int unsigned low_cycles(input int unsigned n_bit_cycles);
        return n_bit_cycles / 2;
    endfunction

endpackage

// File: rtl/config_tx_serializer_tx_bit_timer.sv
// Per-bit cycle counter: produces the bit-end strobe and the registered serial clock phase.
module tx_bit_timer #(
    parameter int unsigned C_BIT_CYCLES = 19,
    parameter int unsigned C_LOW_CYCLES = 9
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic active_i,   // a bit is on the line this cycle
    input  logic run_i,      // a bit will be on the line next cycle
    output logic bit_end_o,
    output logic tx_clk_o
);

    localparam int unsigned CW = $clog2(C_BIT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(C_BIT_CYCLES - 1);
    localparam logic [CW-1:0] LOW  = CW'(C_LOW_CYCLES);

    logic [CW-1:0] count_q, count_d;
    logic          clk_q, clk_d;

    // The clock phase is computed from the next count so the registered
    // TX_CLK lines up with the count shown in the same cycle.
    always_comb begin
        bit_end_o = active_i && (count_q == LAST);
        count_d   = '0;
        if (active_i && !bit_end_o) begin
            count_d = count_q + 1'b1;
        end
        clk_d = run_i && (count_d >= LOW);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            clk_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            clk_q   <= clk_d;
        end
    end

    assign tx_clk_o = clk_q;

endmodule

// File: rtl/config_tx_serializer.sv
// Serial configuration transmitter: START edge, LINE_PERIOD hold-off, then MSB-first
// shift-out of the latched word on TX_DAT/TX_CLK under TX_OE, ending with a TX_END pulse.
module config_tx_serializer
    import config_tx_serializer_pkg::*;
#(
    parameter int unsigned CLOCK_PERIOD_PS = 20833,
    parameter int unsigned BIT_PERIOD_NS   = 400,
    parameter int unsigned C_NO_CFG_BITS   = 24
) (
    input  logic                     CLOCK,
    input  logic                     RESET,
    input  logic                     START,
    input  logic [15:0]              LINE_PERIOD,
    input  logic [C_NO_CFG_BITS-1:0] INPUT,
    output logic                     TX_END,
    output logic                     TX_DAT,
    output logic                     TX_CLK,
    output logic                     TX_OE
);

    localparam int unsigned C_BIT_CYCLES = bit_cycles(CLOCK_PERIOD_PS, BIT_PERIOD_NS);
    localparam int unsigned C_LOW_CYCLES = low_cycles(C_BIT_CYCLES);
    localparam int unsigned BW           = $clog2(C_NO_CFG_BITS + 1);
    localparam logic [BW-1:0] LAST_BIT   = BW'(C_NO_CFG_BITS - 1);

    state_e                   state_q, state_d;
    logic                     start_q;
    logic [15:0]              hold_q, hold_d;
    logic [C_NO_CFG_BITS-1:0] sr_q, sr_d;
    logic [BW-1:0]            bitn_q, bitn_d;
    logic                     end_q, oe_q, dat_q;
    logic                     bit_end;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        sr_d    = sr_q;
        bitn_d  = bitn_q;
        unique case (state_q)
            IDLE: begin
                if (START && !start_q) begin
                    sr_d    = INPUT;
                    hold_d  = LINE_PERIOD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (hold_q == '0) begin
                    state_d = SHIFT;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            SHIFT: begin
                if (bit_end) begin
                    sr_d = {sr_q[C_NO_CFG_BITS-2:0], 1'b0};
                    if (bitn_q == LAST_BIT) begin
                        bitn_d  = '0;
                        state_d = DONE;
                    end else begin
                        bitn_d = bitn_q + 1'b1;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so TX_OE rises on the
    // same edge that enters SHIFT.
    always_ff @(posedge CLOCK) begin
        start_q <= START;
        if (RESET) begin
            state_q <= IDLE;
            hold_q  <= '0;
            sr_q    <= '0;
            bitn_q  <= '0;
            end_q   <= 1'b0;
            oe_q    <= 1'b0;
            dat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            sr_q    <= sr_d;
            bitn_q  <= bitn_d;
            end_q   <= (state_d == DONE);
            oe_q    <= (state_d == SHIFT);
            dat_q   <= (state_d == SHIFT) && sr_d[C_NO_CFG_BITS-1];
        end
    end

    tx_bit_timer #(
        .C_BIT_CYCLES (C_BIT_CYCLES),
        .C_LOW_CYCLES (C_LOW_CYCLES)
    ) u_bit_timer (
        .clk_i     (CLOCK),
        .rst_i     (RESET),
        .active_i  (state_q == SHIFT),
        .run_i     (state_d == SHIFT),
        .bit_end_o (bit_end),
        .tx_clk_o  (TX_CLK)
    );

    assign TX_END = end_q;
    assign TX_OE  = oe_q;
    assign TX_DAT = dat_q;

endmodule

// File: tb/tb_config_tx_serializer.sv
// Directed bench for config_tx_serializer with a bit scoreboard checked on TX_CLK rising edges.
module tb_config_tx_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] line_period = '0;
    logic [23:0] cfg = '0;
    logic        tx_end, tx_dat, tx_clk, tx_oe;

    int checks = 0;
    int failures = 0;
    logic q[$];
    logic clk_prev = 1'b0;
    logic mon_exp;

    config_tx_serializer #(
        .CLOCK_PERIOD_PS (20833),
        .BIT_PERIOD_NS   (400),
        .C_NO_CFG_BITS   (24)
    ) dut (
        .CLOCK       (clk),
        .RESET       (rst),
        .START       (start),
        .LINE_PERIOD (line_period),
        .INPUT       (cfg),
        .TX_END      (tx_end),
        .TX_DAT      (tx_dat),
        .TX_CLK      (tx_clk),
        .TX_OE       (tx_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Receiver model: sample TX_DAT on each TX_CLK rise and pop the expected bit.
    always @(negedge clk) begin
        if (tx_clk && !clk_prev) begin
            check("bits_pending", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                mon_exp = q.pop_front();
                check("tx_dat_bit", 32'(tx_dat), 32'(mon_exp));
            end
        end
        clk_prev = tx_clk;
    end

    task automatic xfer(input logic [23:0] w, input logic [15:0] lp,
                        input bit hold, input bit disturb, input string tag);
        int n, m, first_clk;
        bit done;
        @(posedge clk); #1;
        cfg = w;
        line_period = lp;
        start = 1'b1;
        for (int i = 23; i >= 0; i--) q.push_back(w[i]);
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        if (disturb) begin
            cfg = ~w;
            line_period = lp + 16'd7;
        end
        n = 0;
        while (!tx_oe && n < int'(lp) + 100) begin
            @(posedge clk); #1;
            n++;
            if (disturb && n == 2) start = 1'b1;
            if (disturb && n == 3) start = 1'b0;
        end
        check({tag, "_oe_rise"}, 32'(n), 32'(int'(lp) + 1));
        m = 1;
        first_clk = 0;
        done = 1'b0;
        while (!done && m < 600) begin
            @(posedge clk); #1;
            if (tx_oe) begin
                m++;
                if (tx_clk && first_clk == 0) first_clk = m;
                if (disturb && m == 100) begin
                    start = 1'b1;
                    cfg = 24'($urandom);
                end
                if (disturb && m == 101) start = 1'b0;
            end else begin
                done = 1'b1;
            end
        end
        check({tag, "_oe_len"}, 32'(m), 32'd456);
        check({tag, "_first_clk"}, 32'(first_clk), 32'd10);
        check({tag, "_end_hi"}, 32'(tx_end), 32'd1);
        check({tag, "_dat_idle"}, 32'(tx_dat), 32'd0);
        check({tag, "_clk_idle"}, 32'(tx_clk), 32'd0);
        @(posedge clk); #1;
        check({tag, "_end_lo"}, 32'(tx_end), 32'd0);
        check({tag, "_bits_left"}, 32'(q.size()), 32'd0);
        q.delete();
    endtask

    initial begin
        int cnt;
        // Reset held: outputs stay 0 whatever START does.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            start = i[0];
            check("rst_end", 32'(tx_end), 32'd0);
            check("rst_dat", 32'(tx_dat), 32'd0);
            check("rst_clk", 32'(tx_clk), 32'd0);
            check("rst_oe",  32'(tx_oe),  32'd0);
        end
        // START high across reset release is not a new request.
        start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (tx_oe) cnt++;
        end
        check("no_xfer_after_rst", 32'(cnt), 32'd0);
        start = 1'b0;
        repeat (3) @(posedge clk);

        xfer(24'hAEC9EC, 16'd5, 1'b0, 1'b0, "basic");
        xfer(24'h5A0F33, 16'd0, 1'b0, 1'b0, "lp0");
        xfer(24'hC3A5F0, 16'hFFFF, 1'b0, 1'b0, "lpmax");

        // START held high: exactly one transfer.
        xfer(24'h123456, 16'd3, 1'b1, 1'b0, "held");
        cnt = 0;
        for (int i = 0; i < 1400; i++) begin
            @(posedge clk); #1;
            if (tx_oe) cnt++;
        end
        check("held_single", 32'(cnt), 32'd0);
        start = 1'b0;
        repeat (3) @(posedge clk);
        xfer(24'h123456, 16'd3, 1'b0, 1'b0, "second");

        xfer(24'h96E187, 16'd20, 1'b0, 1'b1, "disturb");

        // Reset in the middle of bit 10: no TX_END, then a clean transfer.
        xfer_reset_block : begin
            @(posedge clk); #1;
            cfg = 24'hF0F00F;
            line_period = 16'd2;
            start = 1'b1;
            for (int i = 23; i >= 0; i--) q.push_back(cfg[i]);
            @(posedge clk); #1;
            start = 1'b0;
            cnt = 0;
            while (!tx_oe && cnt < 50) begin
                @(posedge clk); #1;
                cnt++;
            end
            check("mid_rst_oe_rise", 32'(cnt), 32'd3);
            repeat (10 * 19 + 5) @(posedge clk);
            #1;
            check("mid_rst_oe_before", 32'(tx_oe), 32'd1);
            rst = 1'b1;
            @(posedge clk); #1;
            check("mid_rst_oe",  32'(tx_oe),  32'd0);
            check("mid_rst_dat", 32'(tx_dat), 32'd0);
            check("mid_rst_clk", 32'(tx_clk), 32'd0);
            check("mid_rst_end", 32'(tx_end), 32'd0);
            q.delete();
            rst = 1'b0;
            cnt = 0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk); #1;
                if (tx_end || tx_oe) cnt++;
            end
            check("mid_rst_quiet", 32'(cnt), 32'd0);
        end
        xfer(24'hAEC9EC, 16'd4, 1'b0, 1'b0, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
